// File: rtl/md_defs.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_defs;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_multi(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational signed/unsigned 32x32 multiply and divide; zero latency.
// One shared unsigned divider serves both div and divu via operand magnitudes.
module md_calc
    import md_defs::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign sdiv = (md_op == MD_DIV);
    assign dvd  = (sdiv && a[31]) ? -a : a;
    assign dvs  = (b == 32'd0) ? 32'd1 : ((sdiv && b[31]) ? -b : b);
    assign quo  = dvd / dvs;
    assign rem  = dvd % dvs;

    assign div_zero = (b == 32'd0) && ((md_op == MD_DIV) || (md_op == MD_DIVU));

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                res_lo = (a[31] ^ b[31]) ? -quo : quo;
                res_hi = a[31] ? -rem : rem;
            end
            MD_DIVU: begin
                res_lo = quo;
                res_hi = rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with HI/LO: result latched at start, committed after N busy cycles.
// No backpressure; the pipeline is frozen via stall_req while a D-stage HI/LO user waits.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic               d_md_use,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic               busy,
    output logic               start,
    output logic               stall_req
);

    md_state_t   state;
    logic [3:0]  count;
    logic [31:0] ph;
    logic [31:0] pl;
    logic        pz;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    md_calc u_calc (
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign start     = is_multi(md_op) && !busy;
    assign stall_req = d_md_use && (start || busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            count <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            ph    <= 32'd0;
            pl    <= 32'd0;
            pz    <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        ph    <= res_hi;
                        pl    <= res_lo;
                        pz    <= div_zero;
                        count <= is_mul(md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        busy  <= 1'b1;
                        state <= MD_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi <= a;
                    end else if (md_op == MD_MTLO) begin
                        lo <= a;
                    end
                end
                MD_RUN: begin
                    // Any op arriving here is a stalling bug upstream and is dropped.
                    if (count == 4'd1) begin
                        if (!pz) begin
                            hi <= ph;
                            lo <= pl;
                        end
                        busy  <= 1'b0;
                        count <= 4'd0;
                        state <= MD_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected commits, a negedge monitor checks them.
module tb_md_unit;
    import md_defs::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               d_md_use;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic               busy;
    logic               start;
    logic               stall_req;

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .d_md_use  (d_md_use),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .start     (start),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference arithmetic straight from the ISA definitions using 64-bit integers.
    task automatic model(input logic [MD_OP_W-1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = m_hi;
        rl = m_lo;
        case (op)
            MD_MULT: begin
                p = sx * sy;
                rh = p[63:32];
                rl = p[31:0];
            end
            MD_MULTU: begin
                up = longint'(x) * longint'(y);
                rh = up[63:32];
                rl = up[31:0];
            end
            MD_DIV: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                rh = r[31:0];
                rl = q[31:0];
            end
            MD_DIVU: if (y != 0) begin
                rh = x % y;
                rl = x / y;
            end
            default: ;
        endcase
    endtask

    // Monitor: counts busy cycles, checks stall coupling, and scores each commit.
    int   run       = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            run       = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run++;
                chk("stall_busy", 64'(stall_req), 64'(d_md_use));
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("busy_len", 64'(run), 64'(e.len));
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("stall_fall", 64'(stall_req), 64'(0));
                end
                run = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk("busy_timeout", 64'(1), 64'(0));
    endtask

    task automatic push_exp(input logic [MD_OP_W-1:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        model(op, x, y, e.hi, e.lo);
        e.len = is_mul(op) ? NM : ND;
        m_hi  = e.hi;
        m_lo  = e.lo;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [MD_OP_W-1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic use_d);
        tick();
        md_op    = op;
        a        = x;
        b        = y;
        d_md_use = use_d;
        #1;
        chk("start", 64'(start), 64'(1));
        chk("stall_start", 64'(stall_req), 64'(use_d));
        push_exp(op, x, y);
        tick();
        md_op = MD_NONE;
        wait_idle();
    endtask

    task automatic move(input logic [MD_OP_W-1:0] op, input logic [31:0] x);
        tick();
        md_op = op;
        a     = x;
        #1;
        chk("mt_start", 64'(start), 64'(0));
        tick();
        md_op = MD_NONE;
        if (op == MD_MTHI) m_hi = x;
        else m_lo = x;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
        chk("mt_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [MD_OP_W-1:0] op;
        logic [31:0]        x, y;
        int                 changed;

        reset    = 1'b1;
        md_op    = MD_NONE;
        a        = 32'd0;
        b        = 32'd0;
        d_md_use = 1'b0;
        tick();
        tick();
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;

        issue(MD_MULT,  32'hFFFF_FFFD, 32'd5, 1'b1);
        chk("mult_hi_direct", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo_direct", 64'(lo), 64'hFFFF_FFF1);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(MD_DIVU,  32'd7,         32'd2, 1'b1);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_lo_direct", 64'(lo), 64'hFFFF_FFFD);

        move(MD_MTHI, 32'h11);
        move(MD_MTLO, 32'h22);
        issue(MD_DIV, 32'd100, 32'd0, 1'b1);
        chk("divzero_hi", 64'(hi), 64'h11);
        chk("divzero_lo", 64'(lo), 64'h22);
        move(MD_MTHI, 32'hDEAD_BEEF);
        issue(MD_MULT, 32'd9, 32'd9, 1'b0);

        // Ops while busy must be dropped; only the original mult commits.
        tick();
        md_op = MD_MULT; a = 32'd2; b = 32'd3; d_md_use = 1'b1;
        #1;
        push_exp(MD_MULT, 32'd2, 32'd3);
        tick();
        md_op = MD_MTLO; a = 32'h55;
        tick();
        md_op = MD_MULT; a = 32'd1000; b = 32'd1000;
        #1;
        chk("start_blocked", 64'(start), 64'(0));
        tick();
        md_op = MD_NONE;
        chk("mtlo_ignored", 64'(lo), 64'(32'hFFFF_FFF1 & 32'd81));
        wait_idle();

        // Reset in the third busy cycle of a div aborts the commit.
        tick();
        md_op = MD_DIVU; a = 32'd50; b = 32'd7;
        tick();
        md_op = MD_NONE;
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        changed = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hi != 0 || lo != 0 || busy) changed++;
        end
        chk("no_late_commit", 64'(changed), 64'(0));

        for (int i = 0; i < 40; i++) begin
            op = 3'(MD_MULT + $urandom_range(0, 3));
            x  = $urandom();
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 20));
                2:       y = -32'($urandom_range(1, 20));
                default: y = $urandom();
            endcase
            if (op == MD_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
            issue(op, x, y, 1'($urandom_range(0, 1)));
        end

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
